// File: rtl/branch_pc_unit_pkg.sv
// rtl/branch_pc_unit_pkg.sv - shared constants and types for the branch/PC stage
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pc_state_t;

endpackage

// File: rtl/branch_pc_unit_if.sv
// rtl/branch_pc_unit_if.sv - decode-side branch inputs and fetch-side outputs
interface branch_pc_if;

  logic        stall;
  logic        br_valid;
  logic [31:0] br_pc;
  logic [2:0]  br_funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] i_branch;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        br_taken;
  logic        br_misaligned;
  logic        br_illegal;

  modport master (
    output stall, br_valid, br_pc, br_funct3, rs1_data, rs2_data, i_branch,
    input  pc, pc_valid, flush, br_taken, br_misaligned, br_illegal
  );

  modport slave (
    input  stall, br_valid, br_pc, br_funct3, rs1_data, rs2_data, i_branch,
    output pc, pc_valid, flush, br_taken, br_misaligned, br_illegal
  );

endinterface

// File: rtl/branch_pc_unit_comparator.sv
// rtl/branch_pc_unit_comparator.sv - combinational branch condition evaluation
module branch_comparator
  import branch_pkg::*;
(
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [2:0]  br_funct3,
  output logic        cond_true,
  output logic        illegal
);

  always_comb begin
    cond_true = 1'b0;
    illegal   = 1'b0;
    case (br_funct3)
      F3_BEQ:  cond_true = (rs1_data == rs2_data);
      F3_BNE:  cond_true = (rs1_data != rs2_data);
      F3_BLT:  cond_true = ($signed(rs1_data) <  $signed(rs2_data));
      F3_BGE:  cond_true = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: cond_true = (rs1_data <  rs2_data);
      F3_BGEU: cond_true = (rs1_data >= rs2_data);
      default: illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - fetch PC register, branch resolution and flush FSM
module branch_pc_unit
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  branch_pc_if.slave  bus
);

  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        br_taken_q, br_taken_d;
  logic        br_misaligned_q, br_misaligned_d;
  logic        br_illegal_q, br_illegal_d;

  logic        cond_true;
  logic        illegal;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;

  branch_comparator u_cmp (
    .rs1_data  (bus.rs1_data),
    .rs2_data  (bus.rs2_data),
    .br_funct3 (bus.br_funct3),
    .cond_true (cond_true),
    .illegal   (illegal)
  );

  assign target = bus.br_pc + bus.i_branch;
  assign pc_inc = pc_q + PC_STEP;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    br_taken_d      = 1'b0;
    br_misaligned_d = 1'b0;
    br_illegal_d    = 1'b0;
    redirect        = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!bus.stall) begin
          pc_d = pc_inc;
          if (bus.br_valid) begin
            br_illegal_d = illegal;
            // A misaligned taken target is reported but falls through sequentially.
            if (cond_true && (target[1:0] != 2'b00)) begin
              br_misaligned_d = 1'b1;
            end else if (cond_true) begin
              redirect   = 1'b1;
              pc_d       = target;
              br_taken_d = 1'b1;
              state_d    = FLUSH;
            end
          end
        end
      end
      FLUSH: state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= BOOT;
      pc_q            <= RESET_PC;
      br_taken_q      <= 1'b0;
      br_misaligned_q <= 1'b0;
      br_illegal_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      br_taken_q      <= br_taken_d;
      br_misaligned_q <= br_misaligned_d;
      br_illegal_q    <= br_illegal_d;
    end
  end

  // The accept cycle flushes combinationally to kill the wrong-path fetch in flight.
  assign bus.pc            = pc_q;
  assign bus.pc_valid      = (state_q == RUN);
  assign bus.flush         = (state_q == FLUSH) || redirect;
  assign bus.br_taken      = br_taken_q;
  assign bus.br_misaligned = br_misaligned_q;
  assign bus.br_illegal    = br_illegal_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - scoreboard bench for branch_pc_unit
module tb_branch_pc_unit;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        taken;
    logic        mis;
    logic        ill;
  } exp_t;

  logic clk;
  logic rst;
  branch_pc_if bus_if ();

  branch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: what the fetch stage should be doing, tracked abstractly.
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_flushing;
  bit          p_taken, p_mis, p_ill;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("pc",            bus_if.pc,                   e.pc);
      check("pc_valid",      {31'd0, bus_if.pc_valid},      {31'd0, e.valid});
      check("flush",         {31'd0, bus_if.flush},         {31'd0, e.flush});
      check("br_taken",      {31'd0, bus_if.br_taken},      {31'd0, e.taken});
      check("br_misaligned", {31'd0, bus_if.br_misaligned}, {31'd0, e.mis});
      check("br_illegal",    {31'd0, bus_if.br_illegal},    {31'd0, e.ill});
    end
  end

  function automatic exp_t model_step(input bit r, input bit s, input bit v,
                                      input logic [31:0] bp, input logic [2:0] f,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] imm);
    exp_t e;
    logic [31:0] tgt;
    bit running, take, ill, redirect, mis;
    running  = !m_boot && !m_flushing;
    tgt      = bp + imm;
    take     = 0;
    ill      = 0;
    redirect = 0;
    mis      = 0;
    if (running && !s && v) begin
      case (f)
        3'd0: take = (a == b);
        3'd1: take = (a != b);
        3'd4: take = ($signed(a) <  $signed(b));
        3'd5: take = ($signed(a) >= $signed(b));
        3'd6: take = (a <  b);
        3'd7: take = (a >= b);
        default: ill = 1;
      endcase
      if (take && (tgt % 4 == 0)) redirect = 1;
      else if (take) mis = 1;
    end
    e.pc    = m_pc;
    e.valid = running;
    e.flush = m_flushing || redirect;
    e.taken = p_taken;
    e.mis   = p_mis;
    e.ill   = p_ill;
    p_taken = 0;
    p_mis   = 0;
    p_ill   = 0;
    if (r) begin
      m_pc       = 32'h0;
      m_boot     = 1;
      m_flushing = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_flushing) begin
      m_flushing = 0;
    end else if (!s) begin
      m_pc       = redirect ? tgt : m_pc + 32'd4;
      m_flushing = redirect;
      p_taken    = redirect;
      p_mis      = mis;
      p_ill      = ill;
    end
    return e;
  endfunction

  task automatic drive(input bit r, input bit s, input bit v,
                       input logic [31:0] bp, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm);
    rst              = r;
    bus_if.stall     = s;
    bus_if.br_valid  = v;
    bus_if.br_pc     = bp;
    bus_if.br_funct3 = f;
    bus_if.rs1_data  = a;
    bus_if.rs2_data  = b;
    bus_if.i_branch  = imm;
    sb.push_back(model_step(r, s, v, bp, f, a, b, imm));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 32'h0, 3'd0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    rst              = 1'b1;
    bus_if.stall     = 1'b0;
    bus_if.br_valid  = 1'b0;
    bus_if.br_pc     = 32'h0;
    bus_if.br_funct3 = 3'd0;
    bus_if.rs1_data  = 32'h0;
    bus_if.rs2_data  = 32'h0;
    bus_if.i_branch  = 32'h0;
    @(posedge clk);
    #1;
    m_pc = 32'h0; m_boot = 1; m_flushing = 0;
    p_taken = 0; p_mis = 0; p_ill = 0;

    drive(1, 0, 0, 32'h0, 3'd0, 32'h0, 32'h0, 32'h0);
    drive(1, 0, 0, 32'h0, 3'd0, 32'h0, 32'h0, 32'h0);
    idle(4);

    drive(0, 0, 1, 32'h100, 3'b000, 32'd5, 32'd5, 32'h20);
    idle(3);

    drive(0, 0, 1, 32'h40, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0);
    idle(3);
    drive(0, 0, 1, 32'h40, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0);
    idle(2);

    drive(0, 0, 1, 32'h0, 3'b000, 32'd7, 32'd7, 32'h6);
    idle(2);
    drive(0, 0, 1, 32'h80, 3'b010, 32'd7, 32'd7, 32'h10);
    idle(2);

    for (int i = 0; i < 4; i++) drive(0, 1, 1, 32'h200, 3'b001, 32'd1, 32'd2, 32'h40);
    drive(0, 0, 1, 32'h200, 3'b001, 32'd1, 32'd2, 32'h40);
    idle(3);

    drive(0, 0, 1, 32'hFFFF_FFF0, 3'b000, 32'd3, 32'd3, 32'h20);
    idle(3);

    drive(0, 0, 1, 32'h300, 3'b111, 32'd9, 32'd2, 32'h8);
    drive(1, 0, 0, 32'h0, 3'd0, 32'h0, 32'h0, 32'h0);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b, imm, bp;
      a   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      imm = 32'($urandom_range(0, 511)) - 32'd256;
      imm[0] = 1'b0;
      bp  = $urandom;
      bp[1:0] = 2'b00;
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1), bp, 3'($urandom_range(0, 7)), a, b, imm);
    end
    idle(2);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and branch-resolution stage for the RISC-V core. It consumes the sign-extended, pre-shifted B-type offset produced by the branch-immediate concatenator (`i_branch`) together with the decoded branch operands. It evaluates the branch condition, computes `br_pc + i_branch` and owns the fetch PC register. Prediction is static not-taken; a taken branch costs a two-cycle flush.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 1: hold PC; ignore `br_valid` while high (RUN state only).
- `br_valid` in 1: the decode-stage instruction is a B-type branch with operands ready.
- `br_pc` in 32: PC of that branch.
- `br_funct3` in 3: branch condition.
- `rs1_data` in 32: operand A.
- `rs2_data` in 32: operand B.
- `i_branch` in 32: signed byte offset from the immediate concatenator; bit 0 is always 0.
- `pc` out 32: fetch address.
- `pc_valid` out 1: `pc` is a real fetch this cycle.
- `flush` out 1: kill the instructions in fetch and decode.
- `br_taken` out 1: one-cycle pulse, branch redirected.
- `br_misaligned` out 1: one-cycle pulse, taken target not word-aligned.
- `br_illegal` out 1: one-cycle pulse, `br_funct3` is 010 or 011.

## Operation
- Branch conditions by `br_funct3`:
  - 000 BEQ, 001 BNE.
  - 100 BLT and 101 BGE compare signed.
  - 110 BLTU and 111 BGEU compare unsigned.
  - 010 and 011 raise `br_illegal` and are treated as not taken.
- Target is `br_pc + i_branch`, 32-bit, wrapping modulo 2^32. No overflow flag.
- FSM has three states: BOOT, RUN, FLUSH.
  - BOOT: entered on `rst`. `pc_valid=0`, `pc` holds. Goes to RUN on the next edge unconditionally.
  - RUN with `stall=1`: `pc` holds. Branch input is ignored.
  - RUN with `stall=0`, no branch accepted: `pc <= pc+4`, wrapping.
  - RUN, branch accepted and taken with an aligned target: `pc <= target`, pulse `br_taken`, go to FLUSH.
  - RUN, branch taken with `target[1:0]!=0`: pulse `br_misaligned`, no redirect, `pc <= pc+4`, stay in RUN.
  - RUN, branch not taken: `pc <= pc+4`.
  - FLUSH: `flush=1`, `pc_valid=0`, `pc` holds the target. `br_valid` and `stall` are ignored. Goes to RUN on the next edge, where the target is fetched with `pc_valid=1`.
- `flush` is also asserted combinationally in the RUN cycle where a taken, aligned branch is accepted. This kills the wrong-path fetch.
- `pc_valid` and `flush` decode from the registered state. Pulse outputs are registered.

## Timing
- Reset values: `pc=RESET_PC`, `pc_valid=0`, `flush=0`, `br_taken=0`, `br_misaligned=0`, `br_illegal=0`, state BOOT.
- `rst` overrides every other input in the same cycle, including mid-FLUSH.
- First valid fetch of `RESET_PC` occurs 1 cycle after `rst` falls.
- Taken branch accepted at cycle N:
  - `flush` is high in N (combinational) and in N+1 (FLUSH state).
  - `br_taken` is high in N+1.
  - Target is fetched with `pc_valid=1` in N+2.
  - Penalty is 2 bubbles.
- Pulse outputs last exactly one cycle. Back-to-back branches re-pulse.
- A branch held under `stall` is evaluated in the first cycle `stall=0`; upstream keeps the inputs stable until then.
- A `br_valid` arriving during FLUSH is dropped; it is wrong-path.

## Structure
- `branch_pkg` holds:
  - funct3 localparams: `F3_BEQ`, `F3_BNE`, `F3_BLT`, `F3_BGE`, `F3_BLTU`, `F3_BGEU`.
  - state enum `pc_state_t` {BOOT, RUN, FLUSH}.
  - `PC_STEP = 4`.
- One combinational sub-module, `branch_comparator`, with inputs `rs1_data`, `rs2_data`, `br_funct3` and outputs `cond_true`, `illegal`.
- The PC register, FSM and adder live in the top module.

## Test plan
- Reset: `rst` high for 3 cycles, then low. Required:
  - `pc=0`, `pc_valid=0` during reset and the first cycle after.
  - Then `pc_valid=1` with `pc` = 0, 4, 8.
- BEQ taken, 2-bubble penalty:
  - Stimulus: `br_pc=0x100`, `i_branch=0x20`, `rs1=rs2=5`, `funct3=000`.
  - Required: `br_taken` pulse, `flush` high 2 cycles, next valid `pc=0x120`.
- Backward BLT, signed vs unsigned:
  - BLT with `rs1=0xFFFF_FFFF`, `rs2=1`, `i_branch=0xFFFF_FFF0`, `br_pc=0x40`: taken to `0x30`.
  - BLTU with the same operands: not taken, `pc` continues +4, `flush` stays 0.
- Misaligned and illegal:
  - BEQ taken with `i_branch=0x6` from `br_pc=0x0`: required `br_misaligned` pulse, no flush.
  - `funct3=010`: required `br_illegal` pulse, not taken.
- Stall and wrap:
  - `stall` high 4 cycles while `br_valid`: `pc` frozen; branch resolves on release.
  - `br_pc=0xFFFF_FFF0`, `i_branch=0x20`: target `0x10`.
- Reset mid-FLUSH: assert `rst` in the FLUSH cycle. Required: next cycle `pc=RESET_PC`, `flush=0`, state BOOT.
